game_round_ctrl: RTL

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

---
 rtl/morse_game_pkg.sv | 34 +++
 rtl/morse_word_checker.sv | 58 +++++
 rtl/game_round_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/morse_game_pkg.sv
// Shared definitions for the Morse word game: FSM states, ROM word layout
// and default game dimensions.
package morse_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_LISTEN,
    ST_PASS,
    ST_FAIL,
    ST_DONE
  } state_e;

  // ROM word layout: [LEN_MSB:LEN_LSB] = symbol count, [PAT_W-1:0] = pattern
  localparam int unsigned LEN_MSB = 7;
  localparam int unsigned LEN_LSB = 5;
  localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;
  localparam int unsigned PAT_W   = 5;
  localparam int unsigned MAX_LEN = 5;

  localparam int unsigned DEF_NUM_WORDS = 8;
  localparam int unsigned DEF_LIVES     = 3;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned LIVES_W = 3;

  // A length outside 1..MAX_LEN marks the end of the word table.
  function automatic logic len_is_word(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_LEN));
  endfunction

endpackage

// File: rtl/morse_word_checker.sv
// Holds the current word (length, pattern) and the symbol index, and
// classifies each entered symbol as match / mismatch / word complete.
module morse_word_checker
  import morse_game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             sym_valid_i,
  input  logic             sym_dash_i,
  output logic             match_o,
  output logic             mismatch_o,
  output logic             complete_o
);

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             exp_bit;

  // Compare the entered symbol against the pattern bit at the current index.
  always_comb begin
    exp_bit    = |(pat_q & (PAT_W'(1) << idx_q));
    match_o    = sym_valid_i && (sym_dash_i == exp_bit);
    mismatch_o = sym_valid_i && (sym_dash_i != exp_bit);
    complete_o = match_o && ((idx_q + LEN_W'(1)) == len_q);
  end

  // Load a new word or advance the index on a non-final matching symbol.
  always_comb begin
    len_d = len_q;
    pat_d = pat_q;
    idx_d = idx_q;
    if (load_i) begin
      len_d = len_i;
      pat_d = pat_i;
      idx_d = '0;
    end else if (match_o && !complete_o) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  // Word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      pat_q <= '0;
      idx_q <= '0;
    end else begin
      len_q <= len_d;
      pat_q <= pat_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller for the Morse word game: walks the word ROM, listens to
// player symbols under a per-word timer, and keeps score and lives.
module game_round_ctrl
  import morse_game_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter int unsigned LIVES     = DEF_LIVES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sym_valid,
  input  logic               sym_dash,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [LEN_MSB:0]   rom_data,
  output logic               timer_en,
  output logic               timer_clr,
  input  logic               timeout,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives_left,
  output logic               word_ok,
  output logic               word_fail,
  output logic               game_over,
  output logic               win
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                win_q, win_d;

  logic                chk_load;
  logic                chk_sym;
  logic                chk_match;
  logic                chk_mismatch;
  logic                chk_complete;

  // Symbols only reach the checker in LISTEN and never alongside a timeout,
  // so a simultaneous symbol cannot advance or complete the word.
  assign chk_load = (state_q == ST_LOAD);
  assign chk_sym  = (state_q == ST_LISTEN) && sym_valid && !timeout;

  morse_word_checker u_checker (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (chk_load),
    .len_i       (rom_data[LEN_MSB:LEN_LSB]),
    .pat_i       (rom_data[PAT_W-1:0]),
    .sym_valid_i (chk_sym),
    .sym_dash_i  (sym_dash),
    .match_o     (chk_match),
    .mismatch_o  (chk_mismatch),
    .complete_o  (chk_complete)
  );

  // Next-state, score/lives bookkeeping and word advance.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    score_d = score_q;
    lives_d = lives_q;
    win_d   = win_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          score_d = '0;
          lives_d = LIVES_INIT;
          win_d   = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        if (len_is_word(rom_data[LEN_MSB:LEN_LSB])) begin
          state_d = ST_LISTEN;
        end else begin
          state_d = ST_DONE;
          win_d   = 1'b1;
        end
      end
      ST_LISTEN: begin
        if (timeout || chk_mismatch) begin
          state_d = ST_FAIL;
          lives_d = lives_q - LIVES_W'(1);
        end else if (chk_match && chk_complete) begin
          state_d = ST_PASS;
          if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
        end
      end
      ST_PASS, ST_FAIL: begin
        if ((state_q == ST_FAIL) && (lives_q == '0)) begin
          state_d = ST_DONE;
          win_d   = 1'b0;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          win_d   = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and game registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      score_q <= score_d;
      lives_q <= lives_d;
      win_q   <= win_d;
    end
  end

  // State-decoded outputs.
  always_comb begin
    rom_addr   = addr_q;
    score      = score_q;
    lives_left = lives_q;
    win        = win_q;
    timer_en   = (state_q == ST_LISTEN);
    timer_clr  = (state_q == ST_LOAD);
    word_ok    = (state_q == ST_PASS);
    word_fail  = (state_q == ST_FAIL);
    game_over  = (state_q == ST_DONE);
  end

endmodule
